// File: rtl/updi_pkg.sv
// Shared types and helpers for the UPDI transmit path.
package updi_pkg;

  localparam int unsigned UPDI_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5,
    ST_BREAK  = 3'd6,
    ST_BRK_HI = 3'd7
  } updi_tx_state_t;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [UPDI_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/updi_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module updi_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap at the end of each bit; clear restarts the period on a state change.
  always_comb begin
    bit_tick = (cnt_q == LAST);
    if (clear || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updi_tx.sv
// UPDI transmitter: drains the TX FIFO into 8E2 UART frames and generates BREAKs.
module updi_tx
  import updi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 2,
  parameter int unsigned BREAK_BITS   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       break_req,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAXB_A = (UPDI_DATA_BITS > STOP_BITS) ? UPDI_DATA_BITS : STOP_BITS;
  localparam int unsigned MAXB   = (MAXB_A > BREAK_BITS) ? MAXB_A : BREAK_BITS;
  localparam int unsigned BCW    = $clog2(MAXB + 1);

  localparam logic [BCW-1:0] DATA_LAST  = BCW'(UPDI_DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST  = BCW'(STOP_BITS - 1);
  localparam logic [BCW-1:0] BREAK_LAST = BCW'(BREAK_BITS - 1);

  updi_tx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic           brk_q, brk_d;
  logic           tx_q, tx_d;
  logic           tx_en_q, tx_en_d;
  logic           bit_tick;
  logic           baud_clear;

  // Every state starts its first bit period from zero.
  assign baud_clear = (state_d != state_q) || (state_q == ST_IDLE);

  updi_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  // Next-state, datapath and registered-output precomputation.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_d      = bit_q;
    fifo_rd_en = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (brk_q) begin
          state_d = ST_BREAK;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        shift_d  = fifo_data;
        parity_d = even_parity(fifo_data);
        state_d  = ST_START;
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_q == DATA_LAST) begin
            state_d = ST_PARITY;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (bit_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (bit_tick) begin
          if (bit_q == BREAK_LAST) begin
            state_d = ST_BRK_HI;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_BRK_HI: begin
        if (bit_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) bit_d = '0;

    // A pending request is consumed on BREAK entry; pulses that coincide are absorbed.
    if ((state_q != ST_BREAK) && (state_d == ST_BREAK)) begin
      brk_d = 1'b0;
    end else begin
      brk_d = brk_q | break_req;
    end

    // Line value is derived from the upcoming state so it changes on each bit's first cycle.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_q;
      ST_BREAK:  tx_d = 1'b0;
      default:   tx_d = 1'b1;
    endcase
    tx_en_d = (state_d != ST_IDLE) && (state_d != ST_FETCH);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      bit_q    <= '0;
      brk_q    <= 1'b0;
      tx_q     <= 1'b1;
      tx_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      bit_q    <= bit_d;
      brk_q    <= brk_d;
      tx_q     <= tx_d;
      tx_en_q  <= tx_en_d;
    end
  end

  assign tx    = tx_q;
  assign tx_en = tx_en_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_updi_tx.sv
// Directed bench for updi_tx with a FIFO model and a byte scoreboard.
module tb_updi_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned SB  = 2;
  localparam int unsigned BB  = 12;
  localparam int FRAME = (1 + 8 + 1 + SB) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       break_req = 1'b0;
  logic       fifo_rd_en;
  logic       tx;
  logic       tx_en;
  logic       busy;
  logic       done;

  updi_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB),
    .BREAK_BITS  (BB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .break_req (break_req),
    .tx        (tx),
    .tx_en     (tx_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [7:0] fq[$];
  logic [7:0] sb[$];
  logic s_tx, s_txen, s_busy, s_done, s_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample the current cycle mid-period, then advance; the FIFO model pops on rd_en.
  task automatic tick();
    @(negedge clk);
    s_tx   = tx;
    s_txen = tx_en;
    s_busy = busy;
    s_done = done;
    s_rd   = fifo_rd_en;
    @(posedge clk);
    #1;
    if (s_rd) begin
      pops++;
      if (fq.size() > 0) fifo_data = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit score);
    fq.push_back(b);
    if (score) sb.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tx"}, s_tx, 1);
    chk({tag, " tx_en"}, s_txen, 0);
    chk({tag, " busy"}, s_busy, 0);
    chk({tag, " done"}, s_done, 0);
    chk({tag, " rd_en"}, s_rd, 0);
  endtask

  // IDLE pop cycle followed by the FETCH cycle.
  task automatic begin_byte(input string tag);
    tick();
    chk({tag, " pop rd_en"}, s_rd, 1);
    chk({tag, " pop tx"}, s_tx, 1);
    chk({tag, " pop tx_en"}, s_txen, 0);
    chk({tag, " pop busy"}, s_busy, 0);
    tick();
    chk({tag, " fetch rd_en"}, s_rd, 0);
    chk({tag, " fetch tx"}, s_tx, 1);
    chk({tag, " fetch tx_en"}, s_txen, 0);
    chk({tag, " fetch busy"}, s_busy, 1);
  endtask

  // Called while the DUT is in its first START cycle.
  task automatic check_frame(input string tag, input int brk_a, input int brk_b);
    logic [7:0] b;
    logic par;
    logic exp;
    int bitn;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 1, 0);
      b = 8'h00;
    end else begin
      b = sb.pop_front();
    end
    par = 1'b0;
    for (int k = 0; k < 8; k++) if (b[k]) par = ~par;
    for (int i = 0; i < FRAME; i++) begin
      bitn = i / CPB;
      if (i == brk_a || i == brk_b) break_req = 1'b1;
      tick();
      break_req = 1'b0;
      if (bitn == 0) exp = 1'b0;
      else if (bitn <= 8) exp = b[bitn-1];
      else if (bitn == 9) exp = par;
      else exp = 1'b1;
      chk($sformatf("%s tx[%0d]", tag, i), s_tx, exp);
      chk($sformatf("%s tx_en[%0d]", tag, i), s_txen, 1);
      chk($sformatf("%s done[%0d]", tag, i), s_done, (i == FRAME - 1) ? 1 : 0);
      chk($sformatf("%s busy[%0d]", tag, i), s_busy, 1);
      chk($sformatf("%s rd_en[%0d]", tag, i), s_rd, 0);
    end
  endtask

  // Called while the DUT is in its first BREAK cycle.
  task automatic check_break(input string tag);
    for (int i = 0; i < int'((BB + 1) * CPB); i++) begin
      tick();
      chk($sformatf("%s tx[%0d]", tag, i), s_tx, (i < int'(BB * CPB)) ? 0 : 1);
      chk($sformatf("%s tx_en[%0d]", tag, i), s_txen, 1);
      chk($sformatf("%s done[%0d]", tag, i), s_done, 0);
      chk($sformatf("%s busy[%0d]", tag, i), s_busy, 1);
      chk($sformatf("%s rd_en[%0d]", tag, i), s_rd, 0);
    end
  endtask

  initial begin
    int p0;

    // Reset state
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;

    // Idle with empty FIFO
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_idle("idle100");
    end

    // Single byte 0x55
    p0 = pops;
    push_byte(8'h55, 1'b1);
    begin_byte("t1");
    check_frame("t1", -1, -1);
    tick();
    chk_idle("t1 after");
    chk("t1 pops", pops - p0, 1);

    // Back-to-back 0x01, 0x80 with a two-cycle gap
    p0 = pops;
    push_byte(8'h01, 1'b1);
    push_byte(8'h80, 1'b1);
    begin_byte("t2a");
    check_frame("t2a", -1, -1);
    begin_byte("t2gap");
    check_frame("t2b", -1, -1);
    tick();
    chk_idle("t2 after");
    chk("t2 pops", pops - p0, 2);

    // BREAK from idle
    p0 = pops;
    break_req = 1'b1;
    tick();
    break_req = 1'b0;
    chk_idle("t3 req");
    tick();
    chk_idle("t3 pending");
    check_break("t3 brk");
    tick();
    chk_idle("t3 after");
    chk("t3 pops", pops - p0, 0);

    // Two BREAK pulses mid-frame: frame finishes, one BREAK, then the queued byte
    p0 = pops;
    push_byte(8'hA3, 1'b1);
    push_byte(8'h3C, 1'b1);
    begin_byte("t4a");
    check_frame("t4a", 10, 20);
    tick();
    chk_idle("t4 pending");
    check_break("t4 brk");
    begin_byte("t4b");
    check_frame("t4b", -1, -1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle("t4 after");
    end
    chk("t4 pops", pops - p0, 2);

    // Asynchronous reset mid-DATA
    push_byte(8'h5A, 1'b0);
    begin_byte("t5");
    for (int i = 0; i < 10; i++) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("t5 async tx", tx, 1);
    chk("t5 async tx_en", tx_en, 0);
    chk("t5 async busy", busy, 0);
    chk("t5 async done", done, 0);
    chk("t5 async rd_en", fifo_rd_en, 0);
    tick();
    tick();
    rst = 1'b0;
    p0 = pops;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_idle("t5 after");
    end
    chk("t5 pops", pops - p0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updi_tx.md
Name: updi_tx

Overview:
- Transmit-side consumer of the byte FIFO: drains queued bytes and serialises them onto the single-wire UPDI line as UART frames: start bit, 8 data bits LSB first, even parity, 2 stop bits.
- Also generates the UPDI BREAK (line held low for a programmable number of bit times) on request.
- Sits between the TX FIFO's read side and the half-duplex pad driver.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- STOP_BITS, 2, number of stop bits per frame (UPDI uses 2).
- BREAK_BITS, 12, length of a BREAK low period, in bit times.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_rd_en is high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  one-cycle FIFO pop strobe.
- break_req  in  1  pulse; requests one BREAK.
- tx  out  1  serial line output; idle high.
- tx_en  out  1  pad output enable; high while driving a frame or BREAK.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the last stop bit of a data frame ends.

Behaviour:
- Reset (async, any time): state=IDLE, tx=1, tx_en=0, fifo_rd_en=0, busy=0, done=0, baud/bit counters=0, break_pending=0. A partially sent byte is discarded and is not re-fetched.
- break_pending: set by break_req in any state. Cleared on entry to BREAK. Multiple pulses before service yield one BREAK.
- States: IDLE, FETCH, START, DATA, PARITY, STOP, BREAK, BRK_HI.
- IDLE:
  - If break_pending -> BREAK. BREAK has priority over a non-empty FIFO.
  - Else if !fifo_empty: fifo_rd_en=1 for this cycle only (combinational from state and fifo_empty), -> FETCH.
  - Else stay in IDLE.
- FETCH (1 cycle): latch fifo_data into the shift register, compute parity = XOR of the 8 bits, -> START.
- START: tx=0 for CLKS_PER_BIT cycles, -> DATA.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles, -> PARITY.
- PARITY: tx=parity for CLKS_PER_BIT cycles, -> STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; done=1 on the final cycle; -> IDLE.
- BREAK: tx=0 for BREAK_BITS*CLKS_PER_BIT cycles, -> BRK_HI.
- BRK_HI: tx=1 for CLKS_PER_BIT cycles, -> IDLE. done is not pulsed for a BREAK.
- Output registration:
  - tx and tx_en are registered.
  - tx changes on the first cycle of each state/bit. No glitches.
  - tx_en=1 from the first START cycle through the last STOP cycle, and throughout BREAK/BRK_HI. It is 0 in IDLE and FETCH.
- Latency: pop in cycle N -> FETCH in N+1 -> tx falls at N+2.
- Back-to-back bytes: inter-frame gap of exactly 2 cycles of tx=1 (IDLE + FETCH), with tx_en=0 during the gap.
- Frame length: (1+8+1+STOP_BITS)*CLKS_PER_BIT cycles (48 at CLKS_PER_BIT=4, STOP_BITS=2).
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and reloads to 0 on every state change.
- Bit counter: width $clog2(max(8, STOP_BITS, BREAK_BITS)+1).
- fifo_empty is ignored outside IDLE. fifo_rd_en is never asserted while fifo_empty=1.
- break_req arriving mid-frame: the frame completes unchanged, then BREAK runs before the next FIFO byte.

Decomposition:
- Package updi_pkg:
  - typedef enum for the states above (updi_tx_state_t).
  - localparam UPDI_DATA_BITS=8.
  - function even_parity(byte).
- Sub-module updi_baud_counter (param CLKS_PER_BIT):
  - inputs clk, rst, clear.
  - output bit_tick, which pulses on the last cycle of each bit period.
- The FSM, shift register and bit counter stay in updi_tx.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=2, BREAK_BITS=12):
1. Push 0x55, FIFO non-empty at cycle N -> fifo_rd_en=1 at N only; tx from N+2 = 0,1,0,1,0,1,0,1,0,0,1,1 (4 cycles each, parity 0); done at N+49; tx_en high N+2..N+49.
2. Push 0x01 then 0x80 back-to-back -> parities 1 and 1; second start bit begins exactly 2 cycles after the first frame's last stop cycle; exactly 2 pops total.
3. break_req pulse while idle with FIFO empty -> tx low 48 cycles, high 4 cycles, tx_en high all 52 cycles, no done, no fifo_rd_en.
4. break_req during DATA of byte 0xA3 with 0x3C queued -> 0xA3 frame completes intact (parity 0), then 48-cycle break, then 0x3C frame.
5. Assert rst asynchronously mid-DATA -> tx=1, tx_en=0, busy=0 immediately; after release with FIFO empty, no further activity.
6. FIFO empty for 100 cycles -> fifo_rd_en, tx_en, busy, done stay 0; tx stays 1.
